// File: rtl/fft_spectrum_binner.sv
// Purpose: folds the lower half of an FFT frame into NUM_BARS peak-hold magnitude bars and exposes them through a stable display bank.
// Latency: two pipeline stages per beat; frame_done/frame_err pulse in the 3rd cycle after the final beat is accepted.
// Backpressure: tready drops for exactly three cycles at each frame end while the pipeline drains and the banks commit.
module fft_spectrum_binner #(
    parameter int FFT_LEN  = 256,
    parameter int NUM_BARS = 16,
    parameter int MAG_W    = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [31:0]                 s_axis_tdata,
    input  logic [15:0]                 s_axis_tuser,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    input  logic [$clog2(NUM_BARS)-1:0] bar_rd_addr,
    output logic [MAG_W-1:0]            bar_rd_data,
    output logic                        frame_done,
    output logic                        frame_err
);

    localparam int K_W   = $clog2(FFT_LEN);
    localparam int BAR_W = $clog2(NUM_BARS);

    typedef enum logic [1:0] {ACCUM, DRAIN1, DRAIN2, COMMIT} state_t;

    state_t             state_q;
    state_t             state_d;
    logic               live_q;
    logic               err_q;
    logic [K_W-1:0]     cnt_q;

    logic               accept;
    logic               cnt_last;
    logic               frame_end;

    logic [15:0]        re_abs;
    logic [15:0]        im_abs;
    logic               s1_vld;
    logic               s1_inr;
    logic [BAR_W-1:0]   s1_bin;
    logic [15:0]        s1_re;
    logic [15:0]        s1_im;
    logic [15:0]        mag_max;
    logic [15:0]        mag_min;
    logic [MAG_W-1:0]   mag;

    logic [MAG_W-1:0]   work_bank [NUM_BARS];
    logic [MAG_W-1:0]   disp_bank [NUM_BARS];

    logic               unused_tuser;

    assign unused_tuser = ^s_axis_tuser[15:K_W];

    // tready is purely a function of registered state; live_q keeps it low through reset.
    assign s_axis_tready = live_q && (state_q == ACCUM);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign cnt_last      = (cnt_q == K_W'(FFT_LEN - 1));
    assign frame_end     = accept && (s_axis_tlast || cnt_last);

    // Magnitude of a 16-bit two's complement value; -32768 maps to 32768 within 16 bits.
    assign re_abs = s_axis_tdata[31] ? (~s_axis_tdata[31:16] + 16'd1) : s_axis_tdata[31:16];
    assign im_abs = s_axis_tdata[15] ? (~s_axis_tdata[15:0] + 16'd1) : s_axis_tdata[15:0];

    // Alpha-max-plus-beta-min estimate; peaks at 49152 so it cannot overflow MAG_W.
    assign mag_max = (s1_re >= s1_im) ? s1_re : s1_im;
    assign mag_min = (s1_re >= s1_im) ? s1_im : s1_re;
    assign mag     = MAG_W'(mag_max) + MAG_W'(mag_min >> 1);

    assign bar_rd_data = disp_bank[bar_rd_addr];

    // Marks the first edge after reset release so tready can rise.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    // Stage 1: register absolute values, bar index and lower-half flag.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_vld <= 1'b0;
            s1_inr <= 1'b0;
            s1_bin <= '0;
            s1_re  <= '0;
            s1_im  <= '0;
        end else begin
            s1_vld <= accept;
            s1_inr <= ~s_axis_tuser[K_W-1];
            s1_bin <= s_axis_tuser[K_W-2 -: BAR_W];
            s1_re  <= re_abs;
            s1_im  <= im_abs;
        end
    end

    // Beat counter: counts accepted beats, rewinds when the frame is committed.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else if (state_q == COMMIT) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + K_W'(1);
        end
    end

    // Remember whether the frame that just ended was malformed.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_q <= 1'b0;
        end else if (frame_end) begin
            err_q <= (s_axis_tlast != cnt_last);
        end
    end

    // Stage 2 / working bank: peak-hold per bar, wiped whenever a frame is retired.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_BARS; i++) work_bank[i] <= '0;
        end else if (state_q == COMMIT) begin
            for (int i = 0; i < NUM_BARS; i++) work_bank[i] <= '0;
        end else if (s1_vld && s1_inr && (mag > work_bank[s1_bin])) begin
            work_bank[s1_bin] <= mag;
        end
    end

    // Display bank: takes a parallel snapshot of the working bank only for good frames.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_BARS; i++) disp_bank[i] <= '0;
        end else if ((state_q == COMMIT) && !err_q) begin
            for (int i = 0; i < NUM_BARS; i++) disp_bank[i] <= work_bank[i];
        end
    end

    // FSM state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and frame status pulses.
    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        frame_err  = 1'b0;
        case (state_q)
            ACCUM:  if (frame_end) state_d = DRAIN1;
            DRAIN1: state_d = DRAIN2;
            DRAIN2: state_d = COMMIT;
            COMMIT: begin
                state_d    = ACCUM;
                frame_done = ~err_q;
                frame_err  = err_q;
            end
            default: state_d = ACCUM;
        endcase
    end

endmodule

// File: tb/tb_fft_spectrum_binner.sv
// Directed bench for fft_spectrum_binner: tone frames, peak hold, full-scale corner,
// malformed frames, mid-frame reset and back-to-back streaming with continuous tvalid.
module tb_fft_spectrum_binner;

    logic        aclk;
    logic        aresetn;
    logic [31:0] s_axis_tdata;
    logic [15:0] s_axis_tuser;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [3:0]  bar_rd_addr;
    logic [15:0] bar_rd_data;
    logic        frame_done;
    logic        frame_err;

    int checks;
    int errors;
    int done_cnt;
    int err_cnt;
    int st;

    logic [15:0] re_tab   [256];
    logic [15:0] im_tab   [256];
    logic [15:0] exp_bars [16];

    fft_spectrum_binner dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .bar_rd_addr   (bar_rd_addr),
        .bar_rd_data   (bar_rd_data),
        .frame_done    (frame_done),
        .frame_err     (frame_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Count status pulses away from the active edge.
    always @(negedge aclk) begin
        if (frame_done) done_cnt++;
        if (frame_err)  err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_tab();
        for (int i = 0; i < 256; i++) begin
            re_tab[i] = 16'd0;
            im_tab[i] = 16'd0;
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 16; i++) exp_bars[i] = 16'd0;
    endtask

    // Present beats idx=0..n-1 with tvalid held; tlast on beat last_at (-1 = never).
    task automatic send(input int n, input int last_at, output int stalls);
        int   idx;
        int   cyc;
        logic rdy;
        idx    = 0;
        cyc    = 0;
        stalls = 0;
        while (idx < n && cyc < 4000) begin
            @(negedge aclk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = {re_tab[idx % 256], im_tab[idx % 256]};
            s_axis_tuser  = 16'(idx % 256);
            s_axis_tlast  = (idx == last_at);
            rdy           = s_axis_tready;
            @(posedge aclk);
            if (rdy) idx++;
            else stalls++;
            cyc++;
        end
        check("send_accepted", 32'(idx), 32'(n));
    endtask

    // Called right after the final beat's acceptance edge; checks {tready,done,err} per cycle.
    task automatic end_check(input string tag, input logic exp_done, input logic exp_err);
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check({tag, "_drain1"}, 32'({s_axis_tready, frame_done, frame_err}), 32'd0);
        @(negedge aclk);
        check({tag, "_drain2"}, 32'({s_axis_tready, frame_done, frame_err}), 32'd0);
        @(negedge aclk);
        check({tag, "_commit"}, 32'({s_axis_tready, frame_done, frame_err}), 32'({1'b0, exp_done, exp_err}));
        @(negedge aclk);
        check({tag, "_resume"}, 32'({s_axis_tready, frame_done, frame_err}), 32'd4);
    endtask

    task automatic check_bars(input string tag);
        for (int a = 0; a < 16; a++) begin
            @(negedge aclk);
            bar_rd_addr = 4'(a);
            #1;
            check($sformatf("%s_bar%0d", tag, a), 32'(bar_rd_data), 32'(exp_bars[a]));
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        done_cnt      = 0;
        err_cnt       = 0;
        aresetn       = 1'b0;
        s_axis_tdata  = 32'd0;
        s_axis_tuser  = 16'd0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        bar_rd_addr   = 4'd0;
        clear_tab();
        clear_exp();

        // Power-on reset state and release.
        repeat (3) @(negedge aclk);
        check("rst_outputs", 32'({s_axis_tready, frame_done, frame_err}), 32'd0);
        check("rst_bar0", 32'(bar_rd_data), 32'd0);
        aresetn = 1'b1;
        #1;
        check("rel_tready_before_edge", 32'(s_axis_tready), 32'd0);
        @(negedge aclk);
        check("rel_tready_after_edge", 32'(s_axis_tready), 32'd1);

        // Peak hold within bar 2; mirror bin k=200 ignored.
        clear_tab();
        re_tab[16]  = 16'd300;
        re_tab[17]  = 16'd900;
        re_tab[200] = 16'd5000;
        send(256, 255, st);
        end_check("peak", 1'b1, 1'b0);
        clear_exp();
        exp_bars[2] = 16'd900;
        check_bars("peak");

        // Full-scale negative corner on the last lower-half bin.
        clear_tab();
        re_tab[127] = 16'h8000;
        im_tab[127] = 16'h8000;
        send(256, 255, st);
        end_check("fullscale", 1'b1, 1'b0);
        clear_exp();
        exp_bars[15] = 16'd49152;
        check_bars("fullscale");

        // Single tone: 1000 + 400/2 in bar 2.
        clear_tab();
        re_tab[20] = 16'd1000;
        im_tab[20] = 16'hFE70;
        send(256, 255, st);
        end_check("tone", 1'b1, 1'b0);
        clear_exp();
        exp_bars[2] = 16'd1200;
        check_bars("tone");

        // Early tlast on beat 100: discarded, display keeps 1200.
        clear_tab();
        re_tab[16] = 16'd2000;
        send(100, 99, st);
        end_check("early", 1'b0, 1'b1);
        check_bars("early");

        // 256 beats without tlast: error on beat 256.
        send(256, -1, st);
        end_check("late", 1'b0, 1'b1);
        check("late_bar2", 32'(bar_rd_data), 32'd0);
        bar_rd_addr = 4'd2;
        #1;
        check("late_bar2_kept", 32'(bar_rd_data), 32'd1200);
        check("err_pulses", 32'(err_cnt), 32'd2);
        check("done_pulses", 32'(done_cnt), 32'd3);

        // Reset in the middle of a frame clears the display bank.
        send(50, -1, st);
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        check("midrst_outputs", 32'({s_axis_tready, frame_done, frame_err}), 32'd0);
        clear_exp();
        check_bars("midrst");
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        aresetn       = 1'b1;
        #1;
        check("midrel_tready_before_edge", 32'(s_axis_tready), 32'd0);
        @(negedge aclk);
        check("midrel_tready_after_edge", 32'(s_axis_tready), 32'd1);

        // Back-to-back frames with tvalid held high throughout.
        clear_tab();
        re_tab[127] = 16'd5;
        send(256, 255, st);
        check("b2b_frame1_stalls", 32'(st), 32'd0);
        clear_tab();
        re_tab[0] = 16'd77;
        send(256, 255, st);
        check("b2b_frame2_stalls", 32'(st), 32'd3);
        end_check("b2b", 1'b1, 1'b0);
        check("b2b_done_pulses", 32'(done_cnt), 32'd5);
        clear_exp();
        exp_bars[0] = 16'd77;
        check_bars("b2b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
